// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA request arbiter and bus-hold sequencer (IDLE -> REQ -> ACTIVE -> RELEASE).
// Optional HLDA wait timeout is built only when DMA_ARB_HLDA_TIMEOUT_EN is defined.
module dma_channel_arbiter #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned HLDA_TIMEOUT = 255,
    parameter int unsigned TIMEOUT_W    = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              dreqSense,
    input  logic              dackSense,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] requestReg,
    input  logic              rotatingPri,
    input  logic              ctrlDisable,
    input  logic              HLDA,
    input  logic              transferDone,
    input  logic              EOP_N,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [1:0]        grantChannel,
    output logic [NUM_CH-1:0] swReqClear,
    output logic              timeoutErr
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        ACTIVE  = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    // Elaboration-time sanity checks on the configuration.
    if (NUM_CH != 4) begin : g_bad_num_ch
        $error("dma_channel_arbiter: arbitration logic supports NUM_CH == 4 only");
    end
    if (TIMEOUT_W == 0 || HLDA_TIMEOUT == 0 || HLDA_TIMEOUT > ((1 << TIMEOUT_W) - 1)) begin : g_bad_timeout
        $error("dma_channel_arbiter: HLDA_TIMEOUT does not fit in TIMEOUT_W bits");
    end

    state_t            state;
    logic [1:0]        winner;
    logic [1:0]        pointer;
    logic              rot_lat;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] dreq_q;
    logic [NUM_CH-1:0] dreq_act;
    logic [NUM_CH-1:0] raw_req;
    logic [NUM_CH-1:0] eff_req;
    logic [NUM_CH-1:0] win_onehot;
    logic              req_timeout;

    // First requesting channel found scanning upward from start, wrapping 3 -> 0.
    function automatic logic [1:0] pick(input logic [NUM_CH-1:0] req, input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) pick = idx;
        end
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) dreq_q <= '0;
        else       dreq_q <= DREQ;
    end

    assign dreq_act   = dreqSense ? dreq_q : ~dreq_q;
    assign raw_req    = dreq_act | requestReg;
    assign eff_req    = raw_req & ~maskReg;
    assign win_onehot = NUM_CH'(1) << winner;

    // Acknowledge decoded only from the registered grant, so it cannot glitch on state change.
    assign DACK = dackSense ? grant : ~grant;

`ifdef DMA_ARB_HLDA_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 timeout_q;

    // Fires only when no higher-priority REQ exit (EOP, HLDA, request drop) applies.
    assign req_timeout = (state == REQ) && EOP_N && !HLDA && raw_req[winner]
                         && (wait_cnt == TIMEOUT_W'(HLDA_TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == REQ && !HLDA) wait_cnt <= wait_cnt + TIMEOUT_W'(1);
            else                       wait_cnt <= '0;
            if (req_timeout) timeout_q <= 1'b1;
        end
    end

    assign timeoutErr = timeout_q;
`else
    assign req_timeout = 1'b0;
    assign timeoutErr  = 1'b0;
`endif

    // Bus-hold sequencer; rotation mode is captured at arbitration so later changes do not disturb it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            winner       <= '0;
            pointer      <= '0;
            rot_lat      <= 1'b0;
            grant        <= '0;
            HRQ          <= 1'b0;
            grantValid   <= 1'b0;
            grantChannel <= '0;
            swReqClear   <= '0;
        end else begin
            swReqClear <= '0;
            case (state)
                IDLE: begin
                    if (|eff_req && !ctrlDisable) begin
                        state   <= REQ;
                        winner  <= pick(eff_req, rotatingPri ? pointer : 2'd0);
                        rot_lat <= rotatingPri;
                        HRQ     <= 1'b1;
                    end
                end
                REQ: begin
                    if (!EOP_N) begin
                        state <= IDLE;
                        HRQ   <= 1'b0;
                    end else if (HLDA) begin
                        state        <= ACTIVE;
                        grant        <= win_onehot;
                        grantValid   <= 1'b1;
                        grantChannel <= winner;
                    end else if (!raw_req[winner] || req_timeout) begin
                        state <= IDLE;
                        HRQ   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (transferDone || !EOP_N) begin
                        state      <= RELEASE;
                        HRQ        <= 1'b0;
                        grant      <= '0;
                        grantValid <= 1'b0;
                        swReqClear <= requestReg[winner] ? win_onehot : '0;
                        if (rot_lat) pointer <= winner + 2'd1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    HRQ        <= 1'b0;
                    grant      <= '0;
                    grantValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level priority/pointer model.
`timescale 1ns/1ps
module tb_dma_channel_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic       dreqSense;
    logic       dackSense;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       rotatingPri;
    logic       ctrlDisable;
    logic       HLDA;
    logic       transferDone;
    logic       EOP_N;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;
    logic [3:0] swReqClear;
    logic       timeoutErr;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int ptr    = 0;

    always #5 CLK = ~CLK;

    dma_channel_arbiter dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DREQ         (DREQ),
        .dreqSense    (dreqSense),
        .dackSense    (dackSense),
        .maskReg      (maskReg),
        .requestReg   (requestReg),
        .rotatingPri  (rotatingPri),
        .ctrlDisable  (ctrlDisable),
        .HLDA         (HLDA),
        .transferDone (transferDone),
        .EOP_N        (EOP_N),
        .HRQ          (HRQ),
        .DACK         (DACK),
        .grantValid   (grantValid),
        .grantChannel (grantChannel),
        .swReqClear   (swReqClear),
        .timeoutErr   (timeoutErr)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first requesting channel counting up from start, modulo 4.
    function automatic int ref_pick(input logic [3:0] req, input int start);
        for (int k = 0; k < 4; k++)
            if (req[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] pin(input logic [3:0] v);
        return dreqSense ? v : ~v;
    endfunction

    task automatic set_senses(input logic ds, input logic ks);
        ctrlDisable = 1'b1;
        dreqSense   = ds;
        dackSense   = ks;
        DREQ        = pin(4'h0);
        tick();
        tick();
        ctrlDisable = 1'b0;
    endtask

    // One full request/grant/release transaction; dv (hardware) and sv (software) are exclusive.
    task automatic serve(input logic [3:0] dv, input logic [3:0] sv, input logic [3:0] mk,
                         input logic rot, input int hdly, input int endm, input logic hdrop,
                         input logic abort, output int gch, output logic [3:0] gdack);
        logic [3:0] eff, oh, dack_on, dack_off;
        int w;
        gch   = -1;
        gdack = 4'hx;
        eff   = (dv | sv) & ~mk;
        w     = ref_pick(eff, rot ? ptr : 0);
        DREQ = pin(dv); requestReg = sv; maskReg = mk; rotatingPri = rot;
        dack_off = dackSense ? 4'h0 : 4'hF;
        if (eff == 4'h0) begin
            repeat (3) begin
                tick();
                chk("masked_no_hrq", 8'(HRQ), 8'd0);
            end
            DREQ = pin(4'h0); requestReg = '0; maskReg = '0;
            tick();
            tick();
            return;
        end
        oh      = 4'b0001 << w;
        dack_on = dackSense ? oh : ~oh;
        if (sv == 4'h0) begin
            tick();
            chk("hrq_sync_delay", 8'(HRQ), 8'd0);
        end
        tick();
        chk("hrq_rise", 8'(HRQ), 8'd1);
        repeat (hdly) begin
            tick();
            chk("req_wait_hrq", 8'(HRQ), 8'd1);
            chk("req_wait_dack", 8'(DACK), 8'(dack_off));
            chk("req_wait_gv", 8'(grantValid), 8'd0);
        end
        HLDA = 1'b1;
        tick();
        chk("grant_valid", 8'(grantValid), 8'd1);
        chk("grant_ch", 8'(grantChannel), 8'(w));
        chk("grant_dack", 8'(DACK), 8'(dack_on));
        gch   = int'(grantChannel);
        gdack = DACK;
        if (abort) begin
            #2 RESET = 1'b1;
            #1;
            chk("rst_hrq", 8'(HRQ), 8'd0);
            chk("rst_dack", 8'(DACK), 8'(dack_off));
            chk("rst_gv", 8'(grantValid), 8'd0);
            DREQ = pin(4'h0); requestReg = '0; maskReg = '0; HLDA = 1'b0;
            tick();
            RESET = 1'b0;
            ptr   = 0;
            tick();
            return;
        end
        maskReg     = 4'hF;
        rotatingPri = ~rot;
        if (hdrop) HLDA = 1'b0;
        repeat (hdly % 3) begin
            tick();
            chk("active_hold_dack", 8'(DACK), 8'(dack_on));
            chk("active_hold_hrq", 8'(HRQ), 8'd1);
        end
        if (endm != 1) transferDone = 1'b1;
        if (endm != 0) EOP_N = 1'b0;
        tick();
        transferDone = 1'b0;
        EOP_N        = 1'b1;
        chk("rel_hrq", 8'(HRQ), 8'd0);
        chk("rel_gv", 8'(grantValid), 8'd0);
        chk("rel_dack", 8'(DACK), 8'(dack_off));
        chk("rel_swclr", 8'(swReqClear), sv[w] ? 8'(oh) : 8'd0);
        if (rot) ptr = (w + 1) % 4;
        DREQ = pin(4'h0); requestReg = '0; maskReg = '0; HLDA = 1'b0; rotatingPri = rot;
        tick();
        chk("swclr_one_cycle", 8'(swReqClear), 8'd0);
        chk("idle_hrq", 8'(HRQ), 8'd0);
        tick();
        chk("idle_stays", 8'(HRQ), 8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g;
        logic [3:0] dk;
        int exp_rot[4] = '{2, 3, 0, 1};

        RESET = 1'b1; DREQ = 4'h0; dreqSense = 1'b1; dackSense = 1'b1; maskReg = '0;
        requestReg = '0; rotatingPri = 1'b0; ctrlDisable = 1'b0; HLDA = 1'b0;
        transferDone = 1'b0; EOP_N = 1'b1;
        #12;
        chk("reset_hrq", 8'(HRQ), 8'd0);
        chk("reset_dack", 8'(DACK), 8'd0);
        chk("reset_gv", 8'(grantValid), 8'd0);
        chk("reset_gch", 8'(grantChannel), 8'd0);
        chk("reset_swclr", 8'(swReqClear), 8'd0);
        chk("reset_timeout", 8'(timeoutErr), 8'd0);
        RESET = 1'b0;
        tick();
        tick();

        // Fixed priority, HLDA three cycles after HRQ
        serve(4'b1010, 4'h0, 4'h0, 1'b0, 3, 0, 1'b0, 1'b0, g, dk);
        chk("t1_ch", 8'(g), 8'd1);
        chk("t1_dack", 8'(dk), 8'b0010);

        // Rotating priority with pointer wrap
        serve(4'b0010, 4'h0, 4'h0, 1'b1, 1, 0, 1'b0, 1'b0, g, dk);
        for (int i = 0; i < 4; i++) begin
            serve(4'b1111, 4'h0, 4'h0, 1'b1, i, 0, 1'b0, 1'b0, g, dk);
            chk("t2_rot_order", 8'(g), 8'(exp_rot[i]));
        end

        // Masked software request, then unmasked
        rotatingPri = 1'b0;
        requestReg  = 4'b0100;
        maskReg     = 4'b0100;
        repeat (3) begin
            tick();
            chk("t3_masked_hrq", 8'(HRQ), 8'd0);
        end
        serve(4'h0, 4'b0100, 4'h0, 1'b0, 1, 0, 1'b0, 1'b0, g, dk);
        chk("t3_ch", 8'(g), 8'd2);

        // EOP together with transferDone: single pointer advance
        serve(4'b0011, 4'h0, 4'h0, 1'b1, 1, 2, 1'b1, 1'b0, g, dk);
        chk("t4_first", 8'(g), 8'd0);
        serve(4'b1111, 4'h0, 4'h0, 1'b1, 0, 0, 1'b0, 1'b0, g, dk);
        chk("t4_single_adv", 8'(g), 8'd1);

        // ctrlDisable blocks new arbitration
        ctrlDisable = 1'b1;
        DREQ = pin(4'b0001);
        repeat (3) begin
            tick();
            chk("ctrl_disable_hrq", 8'(HRQ), 8'd0);
        end
        DREQ = pin(4'h0);
        tick();
        tick();
        ctrlDisable = 1'b0;
        tick();
        chk("ctrl_enable_idle", 8'(HRQ), 8'd0);

        // Async reset mid-ACTIVE with active-low DACK
        set_senses(1'b1, 1'b0);
        serve(4'b0001, 4'h0, 4'h0, 1'b0, 1, 0, 1'b0, 1'b1, g, dk);
        serve(4'b1000, 4'h0, 4'h0, 1'b0, 0, 0, 1'b0, 1'b0, g, dk);
        chk("t5_ch3", 8'(g), 8'd3);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            logic [3:0] v;
            logic [3:0] mk;
            logic       s;
            if ($urandom_range(0, 7) == 0) set_senses(1'($urandom), 1'($urandom));
            v  = 4'($urandom_range(1, 15));
            mk = 4'($urandom & $urandom);
            s  = 1'($urandom);
            serve(s ? 4'h0 : v, s ? v : 4'h0, mk, 1'($urandom), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 2)), 1'($urandom), 1'b0, g, dk);
        end

        // HLDA never arrives
        set_senses(1'b1, 1'b1);
        rotatingPri = 1'b0;
        requestReg  = 4'b0001;
        tick();
        chk("t6_hrq_rise", 8'(HRQ), 8'd1);
`ifdef DMA_ARB_HLDA_TIMEOUT_EN
        repeat (254) tick();
        chk("t6_hrq_before_to", 8'(HRQ), 8'd1);
        tick();
        chk("t6_hrq_timeout", 8'(HRQ), 8'd0);
        chk("t6_timeout_err", 8'(timeoutErr), 8'd1);
        requestReg = 4'h0;
        repeat (5) tick();
        chk("t6_timeout_sticky", 8'(timeoutErr), 8'd1);
        chk("t6_idle_hrq", 8'(HRQ), 8'd0);
`else
        repeat (300) tick();
        chk("t6_hrq_held", 8'(HRQ), 8'd1);
        chk("t6_no_timeout", 8'(timeoutErr), 8'd0);
        HLDA = 1'b1;
        tick();
        chk("t6_late_grant", 8'(grantChannel), 8'd0);
        transferDone = 1'b1;
        tick();
        transferDone = 1'b0;
        requestReg   = 4'h0;
        HLDA         = 1'b0;
        chk("t6_release_hrq", 8'(HRQ), 8'd0);
        tick();
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
